// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose
//   Shares one uart_tx byte transmitter between N_REQ byte producers using
//   round-robin arbitration. The downstream uart_tx has no busy indication,
//   so this block times every frame itself. It waits FRAME_BITS bit periods
//   plus an optional idle gap before it issues the next byte.
//   po_data/po_flag connect directly to uart_tx pi_data/pi_flag.
//
// Parameters
//   N_REQ       number of requesters (2..8)
//   UART_BPS    baud rate, must match the attached uart_tx
//   CLK_FREQ    sys_clk frequency in Hz
//   FRAME_BITS  bits per frame (start + data + stop)
//   GAP_CYCLES  extra idle sys_clk cycles after each frame (0 = no gap)
//
// Ports
//   sys_clk    in   1        clock, rising edge
//   sys_rst    in   1        synchronous active-high reset
//   req_valid  in   N_REQ    requester i has a byte pending
//   req_data   in   8*N_REQ  byte of requester i on [8*i+7:8*i]
//   req_ready  out  N_REQ    one-cycle pulse: byte of requester i accepted
//   po_data    out  8        byte to uart_tx
//   po_flag    out  1        one-cycle start pulse to uart_tx
//   busy       out  1        high whenever the FSM is not idle
//   grant_id   out  3        index of the last granted requester
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned UART_BPS   = 9600,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         po_data,
    output logic               po_flag,
    output logic               busy,
    output logic [2:0]         grant_id
);

    // ------------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------------
    localparam int unsigned BAUD_CNT     = CLK_FREQ / UART_BPS;
    localparam int unsigned FRAME_CYCLES = BAUD_CNT * FRAME_BITS;
    localparam int unsigned FRAME_W      = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned GAP_W        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]         LAST_REQ   = 3'(N_REQ - 1);

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StGap
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [FRAME_W-1:0] w_frame_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;
    logic [2:0]         r_last_grant;
    logic [2:0]         w_last_grant_nxt;
    logic [7:0]         r_po_data;
    logic [7:0]         w_po_data_nxt;
    logic               r_po_flag;
    logic               w_po_flag_nxt;
    logic [N_REQ-1:0]   r_req_ready;
    logic [N_REQ-1:0]   w_req_ready_nxt;
    logic               r_busy;
    logic               w_busy_nxt;

    // ------------------------------------------------------------------------
    // Round-robin pick
    // Inputs are zero-padded to the full 8-requester width so that the 3-bit
    // index can address them without width-mismatched selects.
    // ------------------------------------------------------------------------
    logic [7:0]  w_valid_pad;
    logic [63:0] w_data_pad;
    logic [3:0]  w_idx;
    logic [2:0]  w_pick;
    logic        w_found;
    logic [7:0]  w_pick_onehot;
    logic [7:0]  w_pick_data;

    always_comb begin
        w_valid_pad = 8'(req_valid);
        w_data_pad  = 64'(req_data);
        w_idx       = '0;
        w_pick      = r_last_grant;
        w_found     = 1'b0;
        // Search last_grant+1, +2, ... wrapping at N_REQ; the previous
        // winner is checked last so it cannot starve the others.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = {1'b0, r_last_grant} + 4'(k);
            if (w_idx >= 4'(N_REQ)) begin
                w_idx = w_idx - 4'(N_REQ);
            end
            if (!w_found && w_valid_pad[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[2:0];
            end
        end
        w_pick_onehot = 8'h01 << w_pick;
        w_pick_data   = w_data_pad[{w_pick, 3'b000} +: 8];
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // Every output is a register, so its next value is decided here together
    // with the state transition that produces it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_last_grant_nxt = r_last_grant;
        w_po_data_nxt    = r_po_data;
        w_po_flag_nxt    = 1'b0;
        w_req_ready_nxt  = '0;
        w_busy_nxt       = 1'b1;

        unique case (r_state)
            StIdle: begin
                w_busy_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt      = StSend;
                    w_po_data_nxt    = w_pick_data;
                    w_last_grant_nxt = w_pick;
                    w_po_flag_nxt    = 1'b1;
                    w_req_ready_nxt  = w_pick_onehot[N_REQ-1:0];
                    w_busy_nxt       = 1'b1;
                end
            end

            StSend: begin
                w_state_nxt     = StWait;
                w_frame_cnt_nxt = '0;
            end

            StWait: begin
                if (r_frame_cnt == FRAME_LAST) begin
                    w_frame_cnt_nxt = '0;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt   = StGap;
                        w_gap_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = StIdle;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                end
            end

            StGap: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = StIdle;
                    w_busy_nxt    = 1'b0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // Reset aborts any frame in progress at once and leaves requester 0 with
    // top priority.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= StIdle;
            r_frame_cnt  <= '0;
            r_gap_cnt    <= '0;
            r_last_grant <= LAST_REQ;
            r_po_data    <= '0;
            r_po_flag    <= 1'b0;
            r_req_ready  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_po_data    <= w_po_data_nxt;
            r_po_flag    <= w_po_flag_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready = r_req_ready;
    assign po_data   = r_po_data;
    assign po_flag   = r_po_flag;
    assign busy      = r_busy;
    assign grant_id  = r_last_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives randomized byte requesters (per-requester FIFOs, plus short-lived
// requests raised while the arbiter is busy and withdrawn before it goes
// idle) and compares every cycle against a transaction-level model: when the
// arbiter is free it grants the first pending requester after the previous
// winner, then stays busy for FRAME_CYCLES+GAP_CYCLES+1 cycles.
// Short timing parameters keep the run small: FRAME_CYCLES = 10*4 = 40.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int unsigned N      = 4;
    localparam int unsigned BPS    = 100;
    localparam int unsigned CLKF   = 1000;
    localparam int unsigned FBITS  = 4;
    localparam int unsigned GAP    = 3;
    localparam int          FRAME  = (CLKF / BPS) * FBITS;
    localparam int          NCYC   = 4500;
    localparam int          QDEPTH = 8;

    logic           sys_clk = 1'b0;
    logic           sys_rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     po_data;
    logic           po_flag;
    logic           busy;
    logic [2:0]     grant_id;

    always #5 sys_clk = ~sys_clk;

    uart_tx_arbiter #(
        .N_REQ      (N),
        .UART_BPS   (BPS),
        .CLK_FREQ   (CLKF),
        .FRAME_BITS (FBITS),
        .GAP_CYCLES (GAP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Requester FIFOs
    logic [7:0] fifo [N][QDEPTH];
    int         head [N];
    int         cnt  [N];
    logic [7:0] garb [N];
    logic [N-1:0] ghost;

    function automatic void push(input int i, input logic [7:0] b);
        if (cnt[i] < QDEPTH) begin
            fifo[i][(head[i] + cnt[i]) % QDEPTH] = b;
            cnt[i]++;
        end
    endfunction

    // Transaction-level model state
    int         m_rem;   // busy cycles left, 0 = free to grant at next edge
    int         m_last;
    logic       m_flag;
    logic [N-1:0] m_ready;
    logic [7:0] m_data;

    initial begin
        int  g;
        int  j;
        int  r;
        bit  rst_pending;
        logic rst_now;

        sys_rst     = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        ghost       = '0;
        rst_pending = 1'b0;
        m_rem = 0; m_last = N - 1; m_flag = 1'b0; m_ready = '0; m_data = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
            garb[i] = 8'h00;
        end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            // ---------------- stimulus ----------------
            rst_now = (cyc < 3);
            if (cyc == 1500 || cyc == 2200) rst_pending = 1'b1;
            // Mid-frame reset, only while the model is in the frame wait
            if (rst_pending && m_rem > GAP + 5 && m_rem < FRAME + GAP - 2) begin
                rst_now     = 1'b1;
                rst_pending = 1'b0;
            end

            // Directed opener: lone requester, then last grant 2 with 1 and 3 pending
            if (cyc == 5)   push(0, 8'h55);
            if (cyc == 60)  push(2, 8'hA2);
            if (cyc == 100) begin
                push(1, 8'hB1);
                push(3, 8'hB3);
            end
            if (cyc >= 250 && cyc < 2500 && $urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, N - 1);
                if (!ghost[r]) push(r, 8'($urandom));
            end

            // Transient requests: only while busy, gone before the arbiter idles
            if (m_rem <= 1) begin
                ghost = '0;
            end else if ($urandom_range(0, 31) == 0) begin
                r = $urandom_range(0, N - 1);
                if (cnt[r] == 0) ghost[r] = 1'b1;
            end

            for (int i = 0; i < N; i++) begin
                if (cnt[i] != 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = fifo[i][head[i]];
                end else begin
                    req_valid[i] = ghost[i];
                    if (!ghost[i]) garb[i] = 8'($urandom);
                    req_data[8*i +: 8] = garb[i];
                end
            end
            sys_rst = rst_now;

            // ---------------- model ----------------
            m_flag  = 1'b0;
            m_ready = '0;
            if (rst_now) begin
                m_rem  = 0;
                m_last = N - 1;
                m_data = 8'h00;
            end else if (m_rem == 0) begin
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (g < 0 && req_valid[j]) g = j;
                end
                if (g >= 0) begin
                    m_flag     = 1'b1;
                    m_ready[g] = 1'b1;
                    m_data     = req_data[8*g +: 8];
                    m_last     = g;
                    m_rem      = FRAME + GAP + 1;
                end
            end else begin
                m_rem--;
            end

            @(posedge sys_clk);
            @(negedge sys_clk);

            // ---------------- compare ----------------
            check_eq("po_flag",   32'(po_flag),   32'(m_flag));
            check_eq("req_ready", 32'(req_ready), 32'(m_ready));
            check_eq("busy",      32'(busy),      32'(m_rem != 0));
            check_eq("grant_id",  32'(grant_id),  32'(m_last));
            check_eq("po_data",   32'(po_data),   32'(m_data));

            // Requester side of the handshake: consume the accepted byte
            for (int i = 0; i < N; i++) begin
                if (m_ready[i] && cnt[i] > 0) begin
                    head[i] = (head[i] + 1) % QDEPTH;
                    cnt[i]--;
                end
            end
        end

        // Everything queued should have been served by now
        for (int i = 0; i < N; i++) begin
            check_eq("drained", 32'(cnt[i]), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
